// File: rtl/iir_response_meter.sv
// Windowed peak |x| and sum-of-squares meter for the iir_filter output stream.
// Results are presented on a valid/ready port; unaccepted windows are counted as drops.
module iir_response_meter #(
   parameter int unsigned Nd   = 18,
   parameter int unsigned Nwin = 10,
   localparam int unsigned Ne  = 2*Nd - 1 + Nwin
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          dv_in,
   input  logic [Nd-1:0] d_in,
   input  logic          clear,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [Nd-1:0] m_peak,
   output logic [Ne-1:0] m_energy,
   output logic          m_drop
);

   localparam int unsigned Nsq = 2*Nd - 1;

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   logic [Nwin-1:0] r_cnt;
   logic            r_s1_v;
   logic            r_last;
   logic [Nd-1:0]   r_mag;
   logic [Nsq-1:0]  r_sq;
   logic [Nd-1:0]   r_peak_acc;
   logic [Ne-1:0]   r_en_acc;
   logic            r_done;
   logic [Nd-1:0]   r_win_peak;
   logic [Ne-1:0]   r_win_en;
   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_load;
   logic            w_drop_set;
   logic            r_drop_pend;
   logic [Nd-1:0]   r_peak;
   logic [Ne-1:0]   r_energy;
   logic            r_drop;
   logic [Nd-1:0]   w_mag;
   logic [Nsq-1:0]  w_sq;
   logic [Nd-1:0]   w_peak_upd;
   logic [Ne-1:0]   w_en_upd;

   // -2**(Nd-1) maps to 2**(Nd-1), which still fits Nd unsigned bits
   assign w_mag      = d_in[Nd-1] ? (~d_in + Nd'(1)) : d_in;
   assign w_sq       = Nsq'(w_mag) * Nsq'(w_mag);
   assign w_peak_upd = (r_mag > r_peak_acc) ? r_mag : r_peak_acc;
   assign w_en_upd   = r_en_acc + Ne'(r_sq);

   // S1: magnitude, square and end-of-window flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_s1_v <= 1'b0;
         r_last <= 1'b0;
         r_mag  <= '0;
         r_sq   <= '0;
      end else if (clear) begin
         r_cnt  <= '0;
         r_s1_v <= 1'b0;
      end else begin
         r_s1_v <= dv_in;
         if (dv_in) begin
            r_mag  <= w_mag;
            r_sq   <= w_sq;
            r_last <= (r_cnt == {Nwin{1'b1}});
            r_cnt  <= r_cnt + Nwin'(1);
         end
      end
   end

   // S2: accumulate; on the last sample snapshot the window and restart clean
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_peak_acc <= '0;
         r_en_acc   <= '0;
         r_done     <= 1'b0;
         r_win_peak <= '0;
         r_win_en   <= '0;
      end else if (clear) begin
         r_peak_acc <= '0;
         r_en_acc   <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= r_s1_v & r_last;
         if (r_s1_v) begin
            if (r_last) begin
               r_win_peak <= w_peak_upd;
               r_win_en   <= w_en_upd;
               r_peak_acc <= '0;
               r_en_acc   <= '0;
            end else begin
               r_peak_acc <= w_peak_upd;
               r_en_acc   <= w_en_upd;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_drop_set  = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (r_done) begin
               w_load      = 1'b1;
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (r_done) begin
               if (m_ready) w_load     = 1'b1;
               else         w_drop_set = 1'b1;
            end else if (m_ready) begin
               w_state_nxt = ST_EMPTY;
            end
         end
      endcase
   end

   // Result register; held contents stay stable while a result is pending
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_peak      <= '0;
         r_energy    <= '0;
         r_drop      <= 1'b0;
         r_drop_pend <= 1'b0;
      end else if (w_load) begin
         r_peak      <= r_win_peak;
         r_energy    <= r_win_en;
         r_drop      <= r_drop_pend;
         r_drop_pend <= 1'b0;
      end else if (w_drop_set) begin
         r_drop_pend <= 1'b1;
      end
   end

   assign m_valid  = (r_state == ST_FULL);
   assign m_peak   = r_peak;
   assign m_energy = r_energy;
   assign m_drop   = r_drop;

endmodule

// File: tb/tb_iir_response_meter.sv
// Scoreboard bench for iir_response_meter: a 4-sample-window instance and a 1024-sample-window
// instance share stimulus; expected window results are queued as samples are driven.
module tb_iir_response_meter;

   localparam int unsigned Nd   = 18;
   localparam int unsigned Ne2  = 2*Nd - 1 + 2;
   localparam int unsigned Ne10 = 2*Nd - 1 + 10;

   typedef struct packed {
      logic [17:0] peak;
      logic [63:0] energy;
      logic        drop;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            dv_in;
   logic [Nd-1:0]   d_in;
   logic            clear;
   logic            m_ready;
   logic            m_valid2, m_drop2, m_valid10, m_drop10;
   logic [Nd-1:0]   m_peak2, m_peak10;
   logic [Ne2-1:0]  m_energy2;
   logic [Ne10-1:0] m_energy10;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q2[$];
   exp_t q10[$];
   exp_t e2, e10;

   longint m2_peak, m2_en, m10_peak, m10_en;
   int     m2_cnt, m10_cnt;
   bit     model_on2;
   bit     drop_next2;

   always #5 clk = ~clk;

   iir_response_meter #(.Nd(Nd), .Nwin(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .dv_in(dv_in), .d_in(d_in), .clear(clear),
      .m_valid(m_valid2), .m_ready(m_ready), .m_peak(m_peak2),
      .m_energy(m_energy2), .m_drop(m_drop2));

   iir_response_meter #(.Nd(Nd), .Nwin(10)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .dv_in(dv_in), .d_in(d_in), .clear(clear),
      .m_valid(m_valid10), .m_ready(m_ready), .m_peak(m_peak10),
      .m_energy(m_energy10), .m_drop(m_drop10));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m2_peak = 0;  m2_en = 0;  m2_cnt = 0;
      m10_peak = 0; m10_en = 0; m10_cnt = 0;
   endtask

   task automatic model_sample(input longint v);
      longint mag;
      mag = (v < 0) ? -v : v;
      if (mag > m2_peak)  m2_peak  = mag;
      if (mag > m10_peak) m10_peak = mag;
      m2_en  += v * v;
      m10_en += v * v;
      m2_cnt++;
      m10_cnt++;
      if (m2_cnt == 4) begin
         if (model_on2) begin
            q2.push_back('{peak: 18'(m2_peak), energy: 64'(m2_en), drop: drop_next2});
            drop_next2 = 1'b0;
         end
         m2_peak = 0; m2_en = 0; m2_cnt = 0;
      end
      if (m10_cnt == 1024) begin
         q10.push_back('{peak: 18'(m10_peak), energy: 64'(m10_en), drop: 1'b0});
         m10_peak = 0; m10_en = 0; m10_cnt = 0;
      end
   endtask

   // One valid sample followed by gap-1 idle cycles; entered and left at posedge+1
   task automatic drive_sample(input longint v, input int gap);
      dv_in = 1'b1;
      d_in  = Nd'(v);
      model_sample(v);
      step();
      dv_in = 1'b0;
      repeat (gap - 1) step();
   endtask

   task automatic drive_window(input longint v);
      for (int i = 0; i < 4; i++) drive_sample(v, 1);
   endtask

   task automatic do_clear(input bit with_sample);
      clear = 1'b1;
      dv_in = with_sample;
      d_in  = Nd'(7);
      step();
      clear = 1'b0;
      dv_in = 1'b0;
      model_reset();
   endtask

   // Scoreboard: compare each accepted result against the oldest expected one
   always @(negedge clk) begin
      if (rst_n && m_valid2 && m_ready) begin
         check("sb2_pending", 64'(q2.size() != 0), 64'd1);
         if (q2.size() != 0) begin
            e2 = q2.pop_front();
            check("w2_peak",   64'(m_peak2),   64'(e2.peak));
            check("w2_energy", 64'(m_energy2), e2.energy);
            check("w2_drop",   64'(m_drop2),   64'(e2.drop));
         end
      end
      if (rst_n && m_valid10 && m_ready) begin
         check("sb10_pending", 64'(q10.size() != 0), 64'd1);
         if (q10.size() != 0) begin
            e10 = q10.pop_front();
            check("w10_peak",   64'(m_peak10),   64'(e10.peak));
            check("w10_energy", 64'(m_energy10), e10.energy);
            check("w10_drop",   64'(m_drop10),   64'(e10.drop));
         end
      end
   end

   initial begin
      longint v;
      rst_n = 1'b0; dv_in = 1'b0; d_in = '0; clear = 1'b0; m_ready = 1'b1;
      model_on2 = 1'b1; drop_next2 = 1'b0;
      model_reset();
      step(); step();
      check("rst_valid2",  64'(m_valid2),  64'd0);
      check("rst_peak2",   64'(m_peak2),   64'd0);
      check("rst_energy2", 64'(m_energy2), 64'd0);
      check("rst_drop2",   64'(m_drop2),   64'd0);
      check("rst_valid10", 64'(m_valid10), 64'd0);
      rst_n = 1'b1;
      step();

      // T1: back-to-back window, latency and pulse width
      drive_sample(3, 1); drive_sample(-5, 1); drive_sample(2, 1); drive_sample(-1, 1);
      @(negedge clk); check("t1_valid_e0", 64'(m_valid2), 64'd0);
      @(negedge clk); check("t1_valid_e1", 64'(m_valid2), 64'd0);
      @(negedge clk); check("t1_valid_e2", 64'(m_valid2), 64'd1);
      check("t1_peak",   64'(m_peak2),   64'd5);
      check("t1_energy", 64'(m_energy2), 64'd39);
      check("t1_drop",   64'(m_drop2),   64'd0);
      @(negedge clk); check("t1_valid_e3", 64'(m_valid2), 64'd0);
      step();

      // T2: most negative sample at 1-in-7
      for (int i = 0; i < 4; i++) drive_sample(-131072, 7);
      repeat (4) step();

      // T3: stalled consumer, two windows discarded
      m_ready = 1'b0; model_on2 = 1'b0;
      drive_window(1);
      repeat (3) step();
      drive_window(2);
      repeat (3) step();
      check("t3_hold_peak_a", 64'(m_peak2), 64'd1);
      drive_window(4);
      repeat (3) step();
      check("t3_valid",  64'(m_valid2),  64'd1);
      check("t3_peak",   64'(m_peak2),   64'd1);
      check("t3_energy", 64'(m_energy2), 64'd4);
      check("t3_drop",   64'(m_drop2),   64'd0);
      q2.push_back('{peak: 18'd1, energy: 64'd4, drop: 1'b0});
      model_on2 = 1'b1; drop_next2 = 1'b1;
      m_ready = 1'b1;
      repeat (2) step();
      check("t3_valid_after_accept", 64'(m_valid2), 64'd0);
      drive_window(4);
      repeat (4) step();

      // T4: clear mid-window, clear with a coincident sample, clear killing an in-flight window
      drive_sample(7, 1); drive_sample(7, 1);
      do_clear(1'b1);
      drive_sample(1, 1); drive_sample(2, 1); drive_sample(3, 1); drive_sample(4, 1);
      repeat (4) step();
      model_on2 = 1'b0;
      drive_window(9);
      do_clear(1'b0);
      model_on2 = 1'b1;
      repeat (4) step();
      check("t4_inflight_killed", 64'(m_valid2), 64'd0);

      // T5: reset with a held result, a pending drop and a partial window
      m_ready = 1'b0; model_on2 = 1'b0;
      drive_window(5);
      repeat (3) step();
      drive_window(6);
      drive_sample(3, 1); drive_sample(3, 1);
      check("t5_pre_valid", 64'(m_valid2), 64'd1);
      rst_n = 1'b0;
      step();
      check("t5_valid",  64'(m_valid2),  64'd0);
      check("t5_peak",   64'(m_peak2),   64'd0);
      check("t5_energy", 64'(m_energy2), 64'd0);
      check("t5_drop",   64'(m_drop2),   64'd0);
      rst_n = 1'b1;
      model_reset();
      model_on2 = 1'b1; drop_next2 = 1'b0;
      m_ready = 1'b1;
      drive_sample(1, 1); drive_sample(-2, 3); drive_sample(1, 1); drive_sample(0, 2);
      repeat (4) step();

      // T6: 1024-sample sine window at 1-in-7
      do_clear(1'b0);
      for (int k = 0; k < 1024; k++) begin
         v = longint'($rtoi(65535.0 * $sin(2.0 * 3.14159265358979 * 0.0183 * k)));
         drive_sample(v, 7);
      end

      repeat (10) step();
      check("sb2_drained",  64'(q2.size()),  64'd0);
      check("sb10_drained", 64'(q10.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
